// File: rtl/coin_acceptor_pkg.sv
// coin_acceptor_pkg: shared definitions for the coin acceptor.
//   NUM_LANES    number of coin-sensor lanes
//   lane_value() 4-bit coin value carried by each lane (1, 2, 5)
//   lane_state_t per-lane debounce / jam FSM state
package coin_acceptor_pkg;

    localparam int NUM_LANES = 3;

    localparam logic [3:0] VAL_LANE0 = 4'd1;
    localparam logic [3:0] VAL_LANE1 = 4'd2;
    localparam logic [3:0] VAL_LANE2 = 4'd5;

    typedef enum logic [2:0] {
        IDLE,
        CNT,
        HIGH,
        WAIT_LOW,
        JAM
    } lane_state_t;

    function automatic logic [3:0] lane_value(input int lane);
        case (lane)
            0:       lane_value = VAL_LANE0;
            1:       lane_value = VAL_LANE1;
            2:       lane_value = VAL_LANE2;
            default: lane_value = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// coin_debounce: one coin-sensor lane. Two-flop synchroniser followed by a
// debounce / jam-detect FSM.
//   clk, rst   system clock, synchronous active-high reset
//   raw        asynchronous sensor line
//   coin_evt   1-cycle pulse when a coin is recognised
//   jam        registered jam flag, held until the line has been low long enough
module coin_debounce
    import coin_acceptor_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int JAM_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic coin_evt,
    output logic jam
);

    logic        sync1, sync2;
    lane_state_t state;
    logic [7:0]  count;
    logic [7:0]  count_inc;

    // Saturating increment: the counter never wraps.
    assign count_inc = (count == 8'hFF) ? count : count + 8'd1;

    // The event coincides with the edge on which the count reaches DEB_CYCLES,
    // so the arbiter can push on that same edge without an extra stage.
    assign coin_evt = (state == CNT) && sync2 && (count_inc == 8'(DEB_CYCLES));

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            state <= WAIT_LOW;   // a line held high through reset is never counted
            count <= 8'd0;
            jam   <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            case (state)
                IDLE: begin
                    if (sync2) begin
                        state <= CNT;
                        count <= 8'd1;
                    end
                end
                CNT: begin
                    if (sync2) begin
                        count <= count_inc;
                        if (coin_evt) state <= HIGH;
                    end else begin
                        state <= IDLE;
                        count <= 8'd0;
                    end
                end
                HIGH: begin
                    if (sync2) begin
                        count <= count_inc;
                        if (count_inc == 8'(JAM_CYCLES)) begin
                            state <= JAM;
                            jam   <= 1'b1;
                            count <= 8'd0;
                        end
                    end else begin
                        state <= WAIT_LOW;
                        count <= 8'd0;
                    end
                end
                WAIT_LOW, JAM: begin
                    // count now tracks consecutive low samples
                    if (sync2) begin
                        count <= 8'd0;
                    end else if (count_inc == 8'(DEB_CYCLES)) begin
                        state <= IDLE;
                        count <= 8'd0;
                        jam   <= 1'b0;
                    end else begin
                        count <= count_inc;
                    end
                end
                default: begin
                    state <= WAIT_LOW;
                    count <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor: debounces three coin sensors, arbitrates recognised coins,
// queues them and presents each on cint for one cycle.
//   clk, rst     system clock, synchronous active-high reset
//   coin_in[2:0] raw sensor lines ([0]=1, [1]=2, [2]=5 units)
//   accept_en    0 rejects every recognised coin
//   cint_ready   consumer can take a coin this cycle
//   cint         coin value for one cycle per coin, 0 otherwise
//   coin_reject  1-cycle pulse: recognised coin not queued
//   jam[2:0]     per-lane jam flags
//   fifo_full    queue holds FIFO_DEPTH entries
//   total        (only with COIN_TOTAL_EN) saturating sum of values shown on cint
// FIFO_DEPTH must be a power of 2 and at least 2.
module coin_acceptor
    import coin_acceptor_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int JAM_CYCLES = 255,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_LANES-1:0] coin_in,
    input  logic                 accept_en,
    input  logic                 cint_ready,
    output logic [3:0]           cint,
    output logic                 coin_reject,
    output logic [NUM_LANES-1:0] jam,
    output logic                 fifo_full
`ifdef COIN_TOTAL_EN
    ,
    output logic [15:0]          total
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

    logic [NUM_LANES-1:0] evt;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        coin_debounce #(
            .DEB_CYCLES(DEB_CYCLES),
            .JAM_CYCLES(JAM_CYCLES)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .raw      (coin_in[i]),
            .coin_evt (evt[i]),
            .jam      (jam[i])
        );
    end

    logic [1:0]    n_evt;
    logic [3:0]    evt_val;
    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   cnt, cnt_next;
    logic          pop, push, reject;

    always_comb begin
        n_evt   = 2'd0;
        evt_val = 4'd0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (evt[i]) begin
                n_evt   = n_evt + 2'd1;
                evt_val = evt_val | lane_value(i);
            end
        end
    end

    assign pop = cint_ready && (cnt != '0);
    // A pop on the same edge frees a slot, so a full queue can still accept.
    assign push   = (n_evt == 2'd1) && accept_en && ((cnt != DEPTH_L) || pop);
    // Covers disabled, full, and simultaneous (ambiguous) events alike.
    assign reject = (n_evt != 2'd0) && !push;

    always_comb begin
        cnt_next = cnt;
        if (push && !pop)      cnt_next = cnt + 1'b1;
        else if (!push && pop) cnt_next = cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= evt_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            cnt         <= '0;
            cint        <= 4'd0;
            coin_reject <= 1'b0;
            fifo_full   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            cint        <= pop ? mem[rd_ptr] : 4'd0;
            coin_reject <= reject;
            cnt         <= cnt_next;
            fifo_full   <= (cnt_next == DEPTH_L);
        end
    end

`ifdef COIN_TOTAL_EN
    logic [16:0] total_sum;
    assign total_sum = {1'b0, total} + {13'd0, cint};

    always_ff @(posedge clk) begin
        if (rst) total <= 16'd0;
        else     total <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
    end
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
module tb_coin_acceptor;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] coin_in;
    logic       accept_en;
    logic       cint_ready;
    logic [3:0] cint;
    logic       coin_reject;
    logic [2:0] jam;
    logic       fifo_full;
`ifdef COIN_TOTAL_EN
    logic [15:0] total;
`endif

    coin_acceptor dut (
        .clk         (clk),
        .rst         (rst),
        .coin_in     (coin_in),
        .accept_en   (accept_en),
        .cint_ready  (cint_ready),
        .cint        (cint),
        .coin_reject (coin_reject),
        .jam         (jam),
        .fifo_full   (fifo_full)
`ifdef COIN_TOTAL_EN
        ,
        .total       (total)
`endif
    );

    always #5 clk = ~clk;

    // Event monitor: counts reject pulses and cint pulses, logs cint values.
    int         n_cint = 0;
    int         n_rej  = 0;
    logic [3:0] log_v [0:1023];

    always @(negedge clk) begin
        if (coin_reject) n_rej = n_rej + 1;
        if (cint != 4'd0) begin
            log_v[n_cint[9:0]] = cint;
            n_cint = n_cint + 1;
        end
    end

    int checks = 0;
    int errors = 0;
    int exp_total = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [2:0] mask;
        int         hi;
        logic       acc;
        int         ncint;
        logic [3:0] val;
        int         nrej;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int c0, r0;
        logic [3:0] seq_v [5];

        vecs[0] = '{3'b001, 8, 1'b1, 1, 4'd1, 0};
        vecs[1] = '{3'b010, 8, 1'b1, 1, 4'd2, 0};
        vecs[2] = '{3'b100, 8, 1'b1, 1, 4'd5, 0};
        vecs[3] = '{3'b001, 3, 1'b1, 0, 4'd0, 0};  // glitch shorter than debounce
        vecs[4] = '{3'b010, 8, 1'b0, 0, 4'd0, 1};  // accept disabled
        vecs[5] = '{3'b101, 8, 1'b1, 0, 4'd0, 1};  // two lanes at once
        vecs[6] = '{3'b111, 8, 1'b1, 0, 4'd0, 1};  // three lanes at once
        vecs[7] = '{3'b010, 4, 1'b1, 1, 4'd2, 0};  // exactly DEB_CYCLES high
        seq_v[0] = 4'd1; seq_v[1] = 4'd2; seq_v[2] = 4'd5; seq_v[3] = 4'd1; seq_v[4] = 4'd2;

        // 1. reset with all lines held high
        rst = 1'b1; coin_in = 3'b111; accept_en = 1'b1; cint_ready = 1'b1;
        tick(3);
        chk("rst_cint", int'(cint), 0);
        chk("rst_reject", int'(coin_reject), 0);
        chk("rst_jam", int'(jam), 0);
        chk("rst_full", int'(fifo_full), 0);
        rst = 1'b0;
        c0 = n_cint; r0 = n_rej;
        tick(10);
        coin_in = 3'b000;
        tick(8);
        chk("held_cint", n_cint - c0, 0);
        chk("held_reject", n_rej - r0, 0);
        chk("held_jam", int'(jam), 0);

        // 2. latency: cint appears on the 7th edge after the first high sample
        c0 = n_cint; r0 = n_rej;
        coin_in = 3'b100;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            if (k == 6) chk("lat_before", int'(cint), 0);
            if (k == 7) chk("lat_at", int'(cint), 5);
            if (k == 8) chk("lat_after", int'(cint), 0);
        end
        tick(2);
        coin_in = 3'b000;
        tick(12);
        exp_total += 5;
        chk("lat_count", n_cint - c0, 1);
        chk("lat_reject", n_rej - r0, 0);

        // table-driven single-shot vectors
        for (int v = 0; v < 8; v++) begin
            c0 = n_cint; r0 = n_rej;
            accept_en = vecs[v].acc;
            coin_in = vecs[v].mask;
            tick(vecs[v].hi);
            coin_in = 3'b000;
            tick(14);
            accept_en = 1'b1;
            chk($sformatf("vec%0d_cint_n", v), n_cint - c0, vecs[v].ncint);
            chk($sformatf("vec%0d_reject_n", v), n_rej - r0, vecs[v].nrej);
            chk($sformatf("vec%0d_jam", v), int'(jam), 0);
            if (vecs[v].ncint == 1 && n_cint > c0) begin
                chk($sformatf("vec%0d_val", v), int'(log_v[c0[9:0]]), int'(vecs[v].val));
                exp_total += int'(vecs[v].val);
            end
        end

        // 6. queue fill, overflow reject, then drain in order
        cint_ready = 1'b0;
        c0 = n_cint; r0 = n_rej;
        for (int i = 0; i < 5; i++) begin
            coin_in = (seq_v[i] == 4'd1) ? 3'b001 : (seq_v[i] == 4'd2) ? 3'b010 : 3'b100;
            tick(8);
            coin_in = 3'b000;
            tick(8);
            if (i == 2) chk("fifo_full_at3", int'(fifo_full), 0);
            if (i == 3) chk("fifo_full_at4", int'(fifo_full), 1);
        end
        chk("fifo_overflow_reject", n_rej - r0, 1);
        chk("fifo_no_out", n_cint - c0, 0);
        cint_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            chk($sformatf("drain%0d", k), int'(cint), int'(seq_v[k]));
            if (k == 0) chk("fifo_full_drop", int'(fifo_full), 0);
            exp_total += int'(seq_v[k]);
        end
        tick(1);
        chk("drain_idle", int'(cint), 0);
        chk("drain_count", n_cint - c0, 4);
`ifdef COIN_TOTAL_EN
        chk("total", int'(total), exp_total);
`endif

        // 7. jam on lane 0; lane 1 keeps working
        c0 = n_cint;
        coin_in = 3'b001;
        tick(256);
        chk("jam_before", int'(jam), 0);
        tick(1);
        chk("jam_set", int'(jam), 1);
        coin_in = 3'b011;
        tick(8);
        coin_in = 3'b001;
        tick(35);
        chk("jam_held", int'(jam), 1);
        coin_in = 3'b000;
        tick(5);
        chk("jam_low5", int'(jam), 1);
        tick(1);
        chk("jam_clear", int'(jam), 0);
        tick(10);
        chk("jam_cint_n", n_cint - c0, 2);
        if (n_cint - c0 == 2) begin
            chk("jam_val0", int'(log_v[c0[9:0]]), 1);
            chk("jam_val1", int'(log_v[(c0 + 1) & 1023]), 2);
        end

        // reset mid-operation discards a queued coin
        cint_ready = 1'b0;
        coin_in = 3'b100;
        tick(8);
        coin_in = 3'b000;
        tick(8);
        c0 = n_cint;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        cint_ready = 1'b1;
        tick(6);
        chk("rst_discard", n_cint - c0, 0);
        chk("rst_discard_full", int'(fifo_full), 0);
`ifdef COIN_TOTAL_EN
        chk("total_rst", int'(total), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
